// File: rtl/crp16_alu_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : crp16_alu_mul_seq (with crp16_alu_adder)
// Brief    : 16x16 unsigned shift-add multiplier, one shared adder pass per
//            clock. Optional macro: CRP16_MUL_ZERO_BYPASS_EN.
// Revision : 1.0
// ============================================================================

module crp16_alu_adder (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        sub,
   output logic [15:0] sum,
   output logic        c_out,
   output logic        ovf
);
   logic [16:0] w_c;
   logic [15:0] w_b;

   assign w_b    = b ^ {16{sub}};
   assign w_c[0] = sub;

   for (genvar i = 0; i < 16; i++) begin : g_bit
      assign sum[i]   = a[i] ^ w_b[i] ^ w_c[i];
      assign w_c[i+1] = (a[i] & w_b[i]) | (w_c[i] & (a[i] ^ w_b[i]));
   end

   assign c_out = w_c[16];
   assign ovf   = w_c[16] ^ w_c[15];
endmodule

module crp16_alu_mul_seq #(
   parameter bit ACCEPT_IN_DONE = 1'b1
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic        start,
   input  logic [15:0] x,
   input  logic [15:0] y,
   output logic        busy,
   output logic        done,
   output logic [15:0] r_hi,
   output logic [15:0] r_lo,
   output logic        v
);
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [15:0] r_mcand;
   logic [15:0] r_acc;
   logic [15:0] r_mplr;
   logic [4:0]  r_cnt;
   logic        w_accept;
   logic        w_zero;
   logic [15:0] w_addend;
   logic [15:0] w_sum;
   logic        w_cout;
   logic        w_ovf_unused;

   assign w_addend = r_mplr[0] ? r_mcand : 16'd0;

   crp16_alu_adder u_adder (
      .a     (r_acc),
      .b     (w_addend),
      .sub   (1'b0),
      .sum   (w_sum),
      .c_out (w_cout),
      .ovf   (w_ovf_unused)
   );

`ifdef CRP16_MUL_ZERO_BYPASS_EN
   assign w_zero = (x == 16'd0) || (y == 16'd0);
`else
   assign w_zero = 1'b0;
`endif

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_accept = start;
         end
         S_RUN: begin
            busy = 1'b1;
            if (r_cnt == 5'd15) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            done        = 1'b1;
            w_accept    = start && ACCEPT_IN_DONE;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
      // A zero operand short-circuits straight to DONE when bypass is built in
      if (w_accept) begin
         w_state_nxt = w_zero ? S_DONE : S_RUN;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_mcand <= 16'd0;
         r_acc   <= 16'd0;
         r_mplr  <= 16'd0;
         r_cnt   <= 5'd0;
      end else if (w_accept) begin
         r_mcand <= x;
         r_acc   <= 16'd0;
         r_mplr  <= w_zero ? 16'd0 : y;
         r_cnt   <= 5'd0;
      end else if (r_state == S_RUN) begin
         // Carry-out lands in acc[15] so the 33-bit partial sum never loses a bit
         {r_acc, r_mplr} <= {w_cout, w_sum, r_mplr[15:1]};
         r_cnt           <= r_cnt + 5'd1;
      end
   end

   assign r_hi = r_acc;
   assign r_lo = r_mplr;
   assign v    = |r_acc;

endmodule
`default_nettype wire

// File: tb/tb_crp16_alu_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_crp16_alu_mul_seq
// Brief    : Self-checking bench for crp16_alu_mul_seq (both ACCEPT_IN_DONE
//            settings). Honours CRP16_MUL_ZERO_BYPASS_EN.
// Revision : 1.0
// ============================================================================
module tb_crp16_alu_mul_seq;
   logic        clock  = 1'b0;
   logic        resetn = 1'b0;
   logic        start  = 1'b0;
   logic [15:0] x      = 16'd0;
   logic [15:0] y      = 16'd0;
   logic        busy, done, v;
   logic [15:0] r_hi, r_lo;
   logic        busy0, done0, v0;
   logic [15:0] r_hi0, r_lo0;
   int          checks = 0;
   int          errors = 0;

   always #5 clock = ~clock;

   crp16_alu_mul_seq #(.ACCEPT_IN_DONE(1'b1)) dut (
      .clock(clock), .resetn(resetn), .start(start), .x(x), .y(y),
      .busy(busy), .done(done), .r_hi(r_hi), .r_lo(r_lo), .v(v)
   );

   crp16_alu_mul_seq #(.ACCEPT_IN_DONE(1'b0)) dut0 (
      .clock(clock), .resetn(resetn), .start(start), .x(x), .y(y),
      .busy(busy0), .done(done0), .r_hi(r_hi0), .r_lo(r_lo0), .v(v0)
   );

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] hi;
      logic [15:0] lo;
   } vec_t;

   vec_t tbl[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b);
      logic [31:0] wa;
      logic [31:0] wb;
      wa = {16'd0, a};
      wb = {16'd0, b};
      return wa * wb;
   endfunction

   function automatic int exp_lat(input logic [15:0] a, input logic [15:0] b);
`ifdef CRP16_MUL_ZERO_BYPASS_EN
      if (a == 16'd0 || b == 16'd0) return 0;
`endif
      return 16;
   endfunction

   // Precondition: called #1 after an edge with both instances idle.
   task automatic run_mul(input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] exp, input string tag);
      int lat_exp;
      int lat;
      lat_exp = exp_lat(a, b);
      start = 1'b1; x = a; y = b;
      tick();
      start = 1'b0; x = 16'($urandom); y = 16'($urandom);
      lat = -1;
      for (int k = 0; k <= 40; k++) begin
         if (done) begin
            lat = k;
            break;
         end
         if (k < lat_exp) chk($sformatf("%s busy@%0d", tag, k), 32'(busy), 32'd1);
         tick();
      end
      chk($sformatf("%s latency", tag), 32'(lat), 32'(lat_exp));
      chk($sformatf("%s busy_at_done", tag), 32'(busy), 32'd0);
      chk($sformatf("%s product", tag), {r_hi, r_lo}, exp);
      chk($sformatf("%s v", tag), 32'(v), 32'(exp[31:16] != 16'd0));
      tick();
      chk($sformatf("%s done_pulse", tag), 32'(done), 32'd0);
      chk($sformatf("%s hold", tag), {r_hi, r_lo}, exp);
   endtask

   initial begin
      int ndone;
      int lat;
      logic [31:0] got;
      logic [15:0] ra, rb;

      tbl[0]  = '{16'd3,     16'd5,     16'h0000, 16'h000F};
      tbl[1]  = '{16'hFFFF,  16'hFFFF,  16'hFFFE, 16'h0001};
      tbl[2]  = '{16'd2,     16'd7,     16'h0000, 16'h000E};
      tbl[3]  = '{16'h8000,  16'd2,     16'h0001, 16'h0000};
      tbl[4]  = '{16'd10,    16'd10,    16'h0000, 16'h0064};
      tbl[5]  = '{16'h8000,  16'h8000,  16'h4000, 16'h0000};
      tbl[6]  = '{16'h00FF,  16'h0101,  16'h0000, 16'hFFFF};
      tbl[7]  = '{16'h0100,  16'h0100,  16'h0001, 16'h0000};
      tbl[8]  = '{16'h5555,  16'h0000,  16'h0000, 16'h0000};
      tbl[9]  = '{16'h0000,  16'hFFFF,  16'h0000, 16'h0000};
      tbl[10] = '{16'hFFFF,  16'd2,     16'h0001, 16'hFFFE};
      tbl[11] = '{16'hABCD,  16'd1,     16'h0000, 16'hABCD};

      // Reset state
      #7;
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset r_hi", 32'(r_hi), 32'd0);
      chk("reset r_lo", 32'(r_lo), 32'd0);
      chk("reset v",    32'(v),    32'd0);
      #3 resetn = 1'b1;
      tick();

      for (int i = 0; i < 12; i++) begin
         run_mul(tbl[i].a, tbl[i].b, {tbl[i].hi, tbl[i].lo}, $sformatf("vec%0d", i));
      end

      // Start while busy must be ignored and operands not re-sampled
      start = 1'b1; x = 16'h1234; y = 16'h0100;
      tick();
      start = 1'b0; x = 16'd0; y = 16'd0;
      repeat (4) tick();
      start = 1'b1; x = 16'hFFFF; y = 16'hFFFF;
      tick();
      start = 1'b0;
      ndone = 0; got = 32'd0;
      for (int k = 0; k < 40; k++) begin
         if (done) begin
            ndone++;
            if (ndone == 1) got = {r_hi, r_lo};
         end
         tick();
      end
      chk("busy_ignore done_count", 32'(ndone), 32'd1);
      chk("busy_ignore product", got, 32'h0012_3400);

      // Back-to-back acceptance in DONE vs one IDLE cycle
      start = 1'b1; x = 16'd2; y = 16'd7;
      tick();
      start = 1'b0; x = 16'($urandom); y = 16'($urandom);
      repeat (15) tick();
      chk("b2b busy_last_iter", 32'(busy), 32'd1);
      start = 1'b1; x = 16'h8000; y = 16'd2;
      tick();
      chk("b2b first done", 32'(done), 32'd1);
      chk("b2b first product", {r_hi, r_lo}, 32'h0000_000E);
      chk("b2b0 first done", 32'(done0), 32'd1);
      tick();
      chk("b2b busy_next", 32'(busy), 32'd1);
      chk("b2b0 idle_gap busy", 32'(busy0), 32'd0);
      chk("b2b0 idle_gap done", 32'(done0), 32'd0);
      tick();
      start = 1'b0; x = 16'($urandom); y = 16'($urandom);
      chk("b2b0 busy_late", 32'(busy0), 32'd1);
      lat = -1;
      for (int k = 0; k <= 40; k++) begin
         if (done) begin lat = k; break; end
         tick();
      end
      chk("b2b second latency", 32'(lat), 32'd15);
      chk("b2b second product", {r_hi, r_lo}, 32'h0001_0000);
      chk("b2b second v", 32'(v), 32'd1);
      lat = -1;
      for (int k = 0; k <= 40; k++) begin
         if (done0) begin lat = k; break; end
         tick();
      end
      chk("b2b0 second latency", 32'(lat), 32'd1);
      chk("b2b0 second product", {r_hi0, r_lo0}, 32'h0001_0000);
      tick();

      // Asynchronous reset mid-RUN
      start = 1'b1; x = 16'h0F0F; y = 16'h00FF;
      tick();
      start = 1'b0;
      repeat (5) tick();
      #3 resetn = 1'b0;
      #1;
      chk("areset busy", 32'(busy), 32'd0);
      chk("areset done", 32'(done), 32'd0);
      chk("areset r_hi", 32'(r_hi), 32'd0);
      chk("areset r_lo", 32'(r_lo), 32'd0);
      chk("areset v",    32'(v),    32'd0);
      #2 resetn = 1'b1;
      tick();
      ndone = 0;
      for (int k = 0; k < 20; k++) begin
         if (done) ndone++;
         tick();
      end
      chk("areset no_done", 32'(ndone), 32'd0);
      run_mul(16'd10, 16'd10, 32'd100, "after_reset");

      // Randomised operands against the arithmetic model
      for (int i = 0; i < 24; i++) begin
         ra = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
         rb = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
         run_mul(ra, rb, model(ra, rb), $sformatf("rnd%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
